// File: rtl/sha256_seq_if.sv
// CPU-side native bus between the picorv32 core and the SHA-256 sequencer.
interface sha256_seq_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        seq_sel;
  logic        seq_ready;
  logic [31:0] seq_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  seq_sel, seq_ready, seq_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output seq_sel, seq_ready, seq_rdata
  );
endinterface

// File: rtl/sha256_seq.sv
// Sequencer that owns the SHA-256 core register port: the CPU fills a
// 16-word block buffer and writes START, and this block streams the buffer
// into the core, triggers init/next, polls for ready with a timeout and
// copies the 256-bit digest into a CPU-readable buffer.
module sha256_seq #(
  parameter logic [31:0] ADDR           = 32'h4000_6000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  sha256_seq_if.slave bus,
  output logic        sha_cs,
  output logic        sha_we,
  output logic [7:0]  sha_address,
  output logic [31:0] sha_write_data,
  input  logic [31:0] sha_read_data
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIG,
    ST_GAP,
    ST_WAIT,
    ST_READ
  } state_t;

  state_t      state;
  logic [31:0] block_buf  [16];
  logic [31:0] digest_buf [8];
  logic [3:0]  load_idx;
  logic [2:0]  read_idx;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;
  logic        first_blk;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0]  offset;
  logic        bus_write;
  logic        bus_read;
  logic        hit_ctrl;
  logic        hit_status;
  logic        hit_block;
  logic        hit_digest;
  logic        start_req;

  assign bus.seq_sel   = bus.mem_valid && (bus.mem_addr[31:8] == ADDR[31:8]);
  assign bus.seq_ready = bus.seq_sel;

  assign offset     = bus.mem_addr[7:0];
  assign bus_write  = bus.seq_sel && (bus.mem_wstrb != 4'b0000);
  assign bus_read   = bus.seq_sel && (bus.mem_wstrb == 4'b0000);
  assign hit_ctrl   = (offset == 8'h00);
  assign hit_status = (offset == 8'h04);
  assign hit_block  = (offset[7:6] == 2'b01) && (offset[1:0] == 2'b00);
  assign hit_digest = (offset[7:5] == 3'b100) && (offset[1:0] == 2'b00);
  assign start_req  = bus_write && hit_ctrl && bus.mem_wdata[0];

  assign wait_cnt_next = wait_cnt + 8'd1;

  // CPU read mux; unmapped offsets and CTRL read back as zero
  always_comb begin
    bus.seq_rdata = 32'h0;
    if (bus_read) begin
      if (hit_status) begin
        bus.seq_rdata = {29'h0, err, done, busy};
      end else if (hit_block) begin
        bus.seq_rdata = block_buf[offset[5:2]];
      end else if (hit_digest) begin
        bus.seq_rdata = digest_buf[offset[4:2]];
      end
    end
  end

  // Block buffer is CPU-owned and frozen while a compression is running
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) block_buf[i] <= 32'h0;
    end else if (!busy && bus_write && hit_block) begin
      block_buf[offset[5:2]] <= bus.mem_wdata;
    end
  end

  // Sequencer FSM; core-port outputs are registered and set on entry to the state that uses them
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      sha_cs         <= 1'b0;
      sha_we         <= 1'b0;
      sha_address    <= 8'h00;
      sha_write_data <= 32'h0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      load_idx       <= 4'd0;
      read_idx       <= 3'd0;
      wait_cnt       <= 8'd0;
      first_blk      <= 1'b0;
      for (int j = 0; j < 8; j++) digest_buf[j] <= 32'h0;
    end else begin
      if (busy && bus_write && (hit_ctrl || hit_block)) begin
        err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          sha_cs <= 1'b0;
          sha_we <= 1'b0;
          if (start_req) begin
            first_blk      <= bus.mem_wdata[1];
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            load_idx       <= 4'd0;
            state          <= ST_LOAD;
            sha_cs         <= 1'b1;
            sha_we         <= 1'b1;
            sha_address    <= 8'h10;
            sha_write_data <= block_buf[0];
          end
        end
        ST_LOAD: begin
          if (load_idx == 4'd15) begin
            state          <= ST_TRIG;
            sha_address    <= 8'h08;
            sha_write_data <= {29'h0, 1'b1, ~first_blk, first_blk};
          end else begin
            load_idx       <= load_idx + 4'd1;
            sha_address    <= {4'h1, load_idx + 4'd1};
            sha_write_data <= block_buf[load_idx + 4'd1];
          end
        end
        ST_TRIG: begin
          state  <= ST_GAP;
          sha_cs <= 1'b0;
          sha_we <= 1'b0;
        end
        ST_GAP: begin
          state       <= ST_WAIT;
          sha_cs      <= 1'b1;
          sha_we      <= 1'b0;
          sha_address <= 8'h09;
          wait_cnt    <= 8'd0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt_next;
          if (sha_read_data[0]) begin
            state       <= ST_READ;
            read_idx    <= 3'd0;
            sha_address <= 8'h20;
          end else if (wait_cnt_next == TIMEOUT_LIMIT) begin
            state  <= ST_IDLE;
            err    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            sha_cs <= 1'b0;
          end
        end
        ST_READ: begin
          digest_buf[read_idx] <= sha_read_data;
          if (read_idx == 3'd7) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            sha_cs <= 1'b0;
          end else begin
            read_idx    <= read_idx + 3'd1;
            sha_address <= {5'b00100, read_idx + 3'd1};
          end
        end
        default: begin
          state  <= ST_IDLE;
          sha_cs <= 1'b0;
          sha_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
